mdio_mgmt_ctrl: RTL

//  Clause-22 MDIO master that sequences management frames to the board's Ethernet PHY over the

---
 rtl/mdio_mgmt_ctrl.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/mdio_mgmt_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mdio_mgmt_ctrl
// Description : Clause-22 MDIO master. Takes one read/write request at a time,
//               shifts out preamble + ST/OP/PHYAD/REGAD, handles turnaround,
//               moves 16 data bits, then releases the bus for one bit-period
//               before reporting completion.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst_n            clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready   request handshake; accepted only while idle
//   req_write             1 = write frame, 0 = read frame
//   req_phy, req_reg      5-bit PHY and register address
//   req_wdata             16-bit write data
//   rsp_valid             one-cycle completion pulse
//   rsp_rdata             read data, held until the next completion
//   rsp_ta_err            read frame saw no PHY drive-low in the 2nd TA bit
//   busy                  frame in progress (inverse of req_ready)
//   mdio_mdc              management clock
//   mdio_o/mdio_oe/mdio_i split bidirectional data pad
// ============================================================================
module mdio_mgmt_ctrl #(
  parameter int CLK_DIV = 20,
  parameter int PRE_LEN = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_phy,
  input  logic [4:0]  req_reg,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_ta_err,
  output logic        busy,
  output logic        mdio_mdc,
  output logic        mdio_o,
  output logic        mdio_oe,
  input  logic        mdio_i
);

  localparam int               DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0]       PRE_LAST = 5'((PRE_LEN > 0) ? PRE_LEN - 1 : 0);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_HDR  = 3'd2,
    S_TA   = 3'd3,
    S_DATA = 3'd4,
    S_TAIL = 3'd5,
    S_DONE = 3'd6
  } state_t;

  state_t           state;
  logic [DIV_W-1:0] div_cnt;
  logic             first_fall;  // first divider wrap of a frame is a fall event with MDC held low
  logic [4:0]       bit_cnt;
  logic             is_write;
  logic [13:0]      hdr_sr;
  logic [15:0]      wd_sr;
  logic [15:0]      rd_sr;
  logic             ta_bit;
  logic             on_ta2;      // bit on the wire is the 2nd TA bit
  logic             on_data;     // bit on the wire is a data bit

  logic frame_active;
  logic wrap;
  logic fall_ev;
  logic rise_ev;

  assign frame_active = (state != S_IDLE) && (state != S_DONE);
  assign wrap         = frame_active && (div_cnt == DIV_LAST);
  assign fall_ev      = wrap && (first_fall || mdio_mdc);
  assign rise_ev      = wrap && !first_fall && !mdio_mdc;
  assign busy         = ~req_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      div_cnt    <= '0;
      first_fall <= 1'b0;
      bit_cnt    <= 5'd0;
      is_write   <= 1'b0;
      hdr_sr     <= 14'd0;
      wd_sr      <= 16'd0;
      rd_sr      <= 16'd0;
      ta_bit     <= 1'b0;
      on_ta2     <= 1'b0;
      on_data    <= 1'b0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= 16'd0;
      rsp_ta_err <= 1'b0;
      mdio_mdc   <= 1'b0;
      mdio_o     <= 1'b1;
      mdio_oe    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;

      if (frame_active) begin
        if (wrap) begin
          div_cnt    <= '0;
          first_fall <= 1'b0;
          if (!first_fall) mdio_mdc <= ~mdio_mdc;
        end else begin
          div_cnt <= div_cnt + DIV_W'(1);
        end
      end

      // PHY data is captured on the MDC rising edge of the bit on the wire
      if (rise_ev && !is_write) begin
        if (on_ta2)  ta_bit <= mdio_i;
        if (on_data) rd_sr  <= {rd_sr[14:0], mdio_i};
      end

      // Each fall event puts the current (state, bit_cnt) bit on the wire
      if (fall_ev) begin
        on_ta2  <= 1'b0;
        on_data <= 1'b0;
        case (state)
          S_PRE: begin
            mdio_oe <= 1'b1;
            mdio_o  <= 1'b1;
            if (bit_cnt == PRE_LAST) begin
              state   <= S_HDR;
              bit_cnt <= 5'd0;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          S_HDR: begin
            mdio_oe <= 1'b1;
            mdio_o  <= hdr_sr[13];
            hdr_sr  <= {hdr_sr[12:0], 1'b0};
            if (bit_cnt == 5'd13) begin
              state   <= S_TA;
              bit_cnt <= 5'd0;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          S_TA: begin
            mdio_oe <= is_write;
            mdio_o  <= is_write ? (bit_cnt == 5'd0) : 1'b1;
            if (bit_cnt == 5'd0) begin
              bit_cnt <= 5'd1;
            end else begin
              on_ta2  <= 1'b1;
              state   <= S_DATA;
              bit_cnt <= 5'd0;
            end
          end
          S_DATA: begin
            mdio_oe <= is_write;
            mdio_o  <= is_write ? wd_sr[15] : 1'b1;
            wd_sr   <= {wd_sr[14:0], 1'b0};
            on_data <= 1'b1;
            if (bit_cnt == 5'd15) begin
              state   <= S_TAIL;
              bit_cnt <= 5'd0;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          S_TAIL: begin
            mdio_oe <= 1'b0;
            mdio_o  <= 1'b1;
            if (bit_cnt == 5'd0) begin
              bit_cnt <= 5'd1;
            end else begin
              // Closing fall event of the release bit: frame complete
              state      <= S_DONE;
              rsp_valid  <= 1'b1;
              rsp_ta_err <= !is_write && ta_bit;
              if (!is_write) rsp_rdata <= rd_sr;
            end
          end
          default: ;
        endcase
      end

      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            is_write   <= req_write;
            hdr_sr     <= {2'b01, (req_write ? 2'b01 : 2'b10), req_phy, req_reg};
            wd_sr      <= req_wdata;
            state      <= (PRE_LEN > 0) ? S_PRE : S_HDR;
            bit_cnt    <= 5'd0;
            // Preloading the wrap value starts the first bit on the next cycle
            div_cnt    <= DIV_LAST;
            first_fall <= 1'b1;
            ta_bit     <= 1'b0;
            on_ta2     <= 1'b0;
            on_data    <= 1'b0;
            req_ready  <= 1'b0;
          end
        end
        S_DONE: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          mdio_mdc  <= 1'b0;
          div_cnt   <= '0;
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire
